ifu_axi_fetch: RTL and testbench
================================

Name: ifu_axi_fetch

Overview:
- Instruction-fetch bridge between the pipeline's fetch stage and an AXI4-Lite read-only instruction memory port.
- Accepts one PC request at a time, issues the AR/R transaction, buffers the returned instruction, and presents it to the ID segment register with valid/ready.
- Handles pipeline flushes (jump, ecall, mret redirect) by discarding in-flight responses.
- Replaces the single-cycle iram_en/iram_addr/iram_rdata interface.

Parameters:
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction/data width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request valid from PC stage.
- req_addr  input  ADDR_W  fetch PC.
- req_ready  output  1  bridge can accept a request this cycle.
- flush  input  1  redirect; kill any outstanding/held fetch.
- resp_valid  output  1  instruction available.
- resp_inst  output  DATA_W  fetched instruction.
- resp_pc  output  ADDR_W  PC of resp_inst.
- resp_err  output  1  access fault (misaligned or rresp != OKAY).
- resp_ready  input  1  ID stage consumes the response.
- i_araddr  output  ADDR_W  AXI read address.
- i_arvalid  output  1  AXI AR valid.
- i_arready  input  1  AXI AR ready.
- i_rdata  input  DATA_W  AXI read data.
- i_rresp  input  2  AXI read response.
- i_rvalid  input  1  AXI R valid.
- i_rready  output  1  AXI R ready.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE; kill=0.
  - Outputs: req_ready=0 during the reset cycle, then 1. i_arvalid=0, i_rready=0, resp_valid=0, resp_err=0.
  - i_araddr, resp_inst and resp_pc reset to 0.
  - Reset mid-transaction abandons it without completing AXI. Memory is reset together with the CPU.
- States: IDLE, AR, R, HOLD. All outputs are driven from registers or the state; there is no combinational path from i_* to resp_*.
- IDLE:
  - req_ready = !flush.
  - On req_valid & req_ready with req_addr[1:0]==0: latch addr into i_araddr and resp_pc, then go to AR. i_arvalid=1 from the next cycle.
  - On a misaligned address: latch resp_pc, set resp_err=1 and resp_inst=0, go to HOLD. No AXI traffic.
- AR:
  - i_arvalid=1 and i_araddr stable until i_arready.
  - On i_arvalid & i_arready: go to R, drop i_arvalid.
  - flush sets kill=1 but arvalid is NOT withdrawn (AXI rule).
- R:
  - i_rready=1.
  - On i_rvalid with kill=0: capture i_rdata into resp_inst, set resp_err = (i_rresp != 2'b00), go to HOLD.
  - On i_rvalid with kill=1: discard, clear kill, go to IDLE.
  - flush in R sets kill. If flush and i_rvalid coincide, the data is discarded.
- HOLD:
  - resp_valid=1; resp_inst, resp_pc and resp_err stay stable.
  - On resp_ready and no flush: clear resp_valid, go to IDLE.
  - On flush (regardless of resp_ready): clear resp_valid, go to IDLE. The response counts as not consumed.
- Latency:
  - Request accept cycle N gives arvalid at N+1.
  - With arready=1 and rvalid one cycle after the AR handshake, resp_valid rises at N+3.
  - Minimum request-to-request interval is 4 cycles (no overlap; single outstanding transaction).
- kill is only set in AR and R, and always clears when the R beat is dropped.
- Back-to-back: a new request is accepted at earliest the cycle after returning to IDLE.

Decomposition:
- Shared package (cpu_pkg): the fetch state enum (IDLE/AR/R/HOLD) and AXI response codes (RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11).
- Single flat module; no sub-module is warranted. The response buffer is one register set inside the FSM.

Test Plan:
- Basic fetch: req 0x8000_0000, arready=1, rvalid with rdata 0x0010_0093 one cycle later -> resp_valid at N+3, resp_inst=0x0010_0093, resp_pc=0x8000_0000, resp_err=0.
- AR backpressure: arready low for 3 cycles -> i_arvalid held high with i_araddr=0x8000_0004 constant; exactly one AR handshake; response correct.
- Flush in R: flush asserted while waiting, rvalid arrives 2 cycles later with 0xDEAD_BEEF -> resp_valid never asserts; back to IDLE; the next req 0x8000_0100 returns its own data.
- Flush in AR while arready=0 -> arvalid stays high until handshake; the R beat is dropped; no resp_valid.
- Error cases:
  - rresp=2'b10 -> resp_valid with resp_err=1.
  - req_addr=0x8000_0002 -> resp_err=1 at N+1 with zero AXI handshakes.
- HOLD backpressure and reset:
  - resp_ready low for 5 cycles -> outputs stable, req_ready=0; release consumes the response.
  - rst asserted in state R -> the next cycle shows all outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-fetch FSM states and AXI response codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than OKAY is an access fault for instruction fetch;
  // EXOKAY has no meaning on a Lite port and is treated as a fault too.
  function automatic logic resp_is_fault(input logic [1:0] resp);
    logic fault;
    case (resp)
      RESP_OKAY:   fault = 1'b0;
      RESP_SLVERR: fault = 1'b1;
      RESP_DECERR: fault = 1'b1;
      default:     fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch bridge: one PC request at a time is turned into an
// AXI4-Lite AR/R transaction; the returned word is held for the ID stage.
// Flushes poison an in-flight transaction so its data beat is dropped.
import cpu_pkg::*;

module ifu_axi_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // PC stage request
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  // ID stage response
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_inst,
  output logic [ADDR_W-1:0] resp_pc,
  output logic              resp_err,
  input  logic              resp_ready,
  // AXI4-Lite read channels
  output logic [ADDR_W-1:0] i_araddr,
  output logic              i_arvalid,
  input  logic              i_arready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              i_rready
);

  fetch_state_e      state_q, state_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              err_q, err_d;
  logic              misaligned;

  assign misaligned = (req_addr[1:0] != 2'b00);

  // Handshake outputs come straight from the state; response data from registers.
  assign req_ready  = (state_q == IDLE) && !flush && !rst;
  assign i_arvalid  = (state_q == AR);
  assign i_rready   = (state_q == R);
  assign resp_valid = (state_q == HOLD);
  assign i_araddr   = araddr_q;
  assign resp_pc    = pc_q;
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;

  // State and response-buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kill_q   <= 1'b0;
      araddr_q <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      araddr_q <= araddr_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept, address phase, data phase, hold for ID.
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    araddr_d = araddr_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          pc_d = req_addr;
          if (misaligned) begin
            // Fault is reported locally; the bus never sees this address.
            inst_d  = '0;
            err_d   = 1'b1;
            state_d = HOLD;
          end else begin
            araddr_d = req_addr;
            err_d    = 1'b0;
            kill_d   = 1'b0;
            state_d  = AR;
          end
        end
      end

      AR: begin
        // arvalid cannot be withdrawn once raised, so a flush only marks
        // the transaction for discard.
        if (flush) begin
          kill_d = 1'b1;
        end
        if (i_arready) begin
          state_d = R;
        end
      end

      R: begin
        if (i_rvalid) begin
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            inst_d  = i_rdata;
            err_d   = resp_is_fault(i_rresp);
            state_d = HOLD;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        // A flush drops the held word whether or not ID took it.
        if (flush || resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Self-checking bench for ifu_axi_fetch: directed vector table, hand-written
// flush/backpressure/reset sequences, and a randomized run against a
// transaction-level reference model with a randomized AXI slave.
module tb_ifu_axi_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic [31:0] resp_pc;
  logic        resp_err;
  logic        resp_ready;
  logic [31:0] i_araddr;
  logic        i_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        i_rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_axi_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .resp_pc    (resp_pc),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .i_araddr   (i_araddr),
    .i_arvalid  (i_arvalid),
    .i_arready  (i_arready),
    .i_rdata    (i_rdata),
    .i_rresp    (i_rresp),
    .i_rvalid   (i_rvalid),
    .i_rready   (i_rready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  rresp;
    int          ar_delay;
    int          r_delay;
    int          exp_lat;
    logic [31:0] exp_inst;
    logic        exp_err;
    int          exp_arhs;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0010_0093;
  endfunction

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_addr   = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    i_arready  = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    i_rresp    = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  req_ready,  1);
    chk({tag, "_arvalid"},    i_arvalid,  0);
    chk({tag, "_rready"},     i_rready,   0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"},   resp_err,   0);
    chk({tag, "_araddr"},     i_araddr,   0);
    chk({tag, "_resp_inst"},  resp_inst,  0);
    chk({tag, "_resp_pc"},    resp_pc,    0);
  endtask

  // One fetch with a scripted slave; leaves the DUT in HOLD unless consume.
  task automatic run_fetch(input vec_t v, input bit consume);
    int cyc, ar_cnt, r_cnt, arhs;
    bit r_phase, got;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = v.addr;
    #1 chk("accept_ready", req_ready, 1);
    @(posedge clk);
    cyc = 0; ar_cnt = 0; r_cnt = 0; arhs = 0; r_phase = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      i_arready = i_arvalid && (ar_cnt >= v.ar_delay);
      if (i_arvalid) ar_cnt++;
      i_rvalid = r_phase && (r_cnt >= v.r_delay);
      i_rdata  = i_rvalid ? v.data : 32'h0BAD_0BAD;
      i_rresp  = i_rvalid ? v.rresp : 2'b01;
      if (r_phase) r_cnt++;
      #1;
      if (i_arvalid) chk("araddr_stable", i_araddr, v.addr);
      if (resp_valid) got = 1;
      if (i_arvalid && i_arready) begin
        arhs++;
        r_phase = 1;
      end
      if (i_rvalid && i_rready) r_phase = 0;
    end
    i_arready = 1'b0;
    i_rvalid  = 1'b0;
    chk("resp_latency", cyc, v.exp_lat);
    chk("resp_inst", resp_inst, v.exp_inst);
    chk("resp_pc", resp_pc, v.addr);
    chk("resp_err", resp_err, v.exp_err);
    chk("ar_handshakes", arhs, v.exp_arhs);
    if (consume) begin
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      chk("resp_dropped", resp_valid, 0);
      chk("ready_after", req_ready, 1);
    end
  endtask

  // Reference model (transaction level) and random slave state
  bit          m_busy, m_mis, m_ar_done, m_r_done, m_killed;
  logic [31:0] m_pc;
  logic [1:0]  m_resp;
  bit          s_pend;
  int          s_delay;
  logic [31:0] s_addr;
  logic [1:0]  s_resp;

  task automatic random_run(input int ncycles);
    bit exp_arvalid, exp_rready, exp_resp_valid, ar_fire, r_fire, m_ar_fire, m_r_fire, kill_now;
    int unsigned off;
    m_busy = 0; m_mis = 0; m_ar_done = 0; m_r_done = 0; m_killed = 0;
    m_pc = '0; m_resp = '0; s_pend = 0; s_delay = 0; s_addr = '0; s_resp = '0;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      off        = ($urandom_range(7) == 0) ? $urandom_range(3, 1) : 0;
      req_valid  = ($urandom_range(3) != 0);
      req_addr   = 32'h8000_0000 + ($urandom_range(255) << 2) + off;
      flush      = ($urandom_range(11) == 0);
      resp_ready = ($urandom_range(2) != 0);
      i_arready  = ($urandom_range(2) != 0);
      i_rvalid   = s_pend && (s_delay == 0);
      i_rdata    = i_rvalid ? mem_word(s_addr) : $urandom;
      i_rresp    = i_rvalid ? s_resp : 2'($urandom);
      #1;
      exp_arvalid    = m_busy && !m_mis && !m_ar_done;
      exp_rready     = m_busy && !m_mis && m_ar_done && !m_r_done;
      exp_resp_valid = m_busy && (m_mis || m_r_done);
      chk("rnd_req_ready", req_ready, !m_busy && !flush);
      chk("rnd_arvalid", i_arvalid, exp_arvalid);
      chk("rnd_rready", i_rready, exp_rready);
      chk("rnd_resp_valid", resp_valid, exp_resp_valid);
      if (exp_arvalid) chk("rnd_araddr", i_araddr, m_pc);
      if (exp_resp_valid) begin
        chk("rnd_resp_pc", resp_pc, m_pc);
        chk("rnd_resp_inst", resp_inst, m_mis ? 32'h0 : mem_word(m_pc));
        chk("rnd_resp_err", resp_err, m_mis ? 1'b1 : (m_resp != 2'b00));
      end
      ar_fire   = i_arvalid && i_arready;
      r_fire    = i_rvalid && i_rready;
      m_ar_fire = exp_arvalid && i_arready;
      m_r_fire  = exp_rready && i_rvalid;
      @(posedge clk);
      // model update for the transaction in flight
      if (!m_busy) begin
        if (req_valid && !flush) begin
          m_busy = 1; m_pc = req_addr; m_mis = (req_addr[1:0] != 2'b00);
          m_ar_done = 0; m_r_done = 0; m_killed = 0;
        end
      end else if (m_mis || m_r_done) begin
        if (flush || resp_ready) m_busy = 0;
      end else if (!m_ar_done) begin
        if (flush) m_killed = 1;
        if (m_ar_fire) m_ar_done = 1;
      end else begin
        kill_now = m_killed || flush;
        if (m_r_fire) begin
          if (kill_now) m_busy = 0;
          else begin
            m_r_done = 1;
            m_resp   = s_resp;
          end
        end else begin
          m_killed = kill_now;
        end
      end
      // slave update
      if (ar_fire) begin
        s_pend  = 1;
        s_delay = $urandom_range(2);
        s_addr  = i_araddr;
        s_resp  = ($urandom_range(4) == 0) ? (($urandom_range(1) == 0) ? 2'b10 : 2'b11) : 2'b00;
      end else if (s_pend) begin
        if (r_fire) s_pend = 0;
        else if (s_delay > 0) s_delay--;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            addr          data          rresp  ard rd lat exp_inst      err  arhs
    vecs[0] = '{32'h8000_0000, 32'h0010_0093, 2'b00, 0, 0, 3, 32'h0010_0093, 1'b0, 1};
    vecs[1] = '{32'h8000_0004, 32'h00A0_0113, 2'b00, 3, 0, 6, 32'h00A0_0113, 1'b0, 1};
    vecs[2] = '{32'h8000_0008, 32'h1234_5678, 2'b10, 0, 0, 3, 32'h1234_5678, 1'b1, 1};
    vecs[3] = '{32'h8000_000C, 32'hCAFE_F00D, 2'b11, 1, 1, 5, 32'hCAFE_F00D, 1'b1, 1};
    vecs[4] = '{32'h8000_0002, 32'h1111_1111, 2'b00, 0, 0, 1, 32'h0000_0000, 1'b1, 0};
    vecs[5] = '{32'h8000_0003, 32'h2222_2222, 2'b00, 0, 0, 1, 32'h0000_0000, 1'b1, 0};
    vecs[6] = '{32'h8000_0010, 32'h0040_0513, 2'b00, 0, 2, 5, 32'h0040_0513, 1'b0, 1};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("reset_cycle_req_ready", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    #1 chk_reset_outputs("reset");

    for (int i = 0; i < 7; i++) run_fetch(vecs[i], 1'b1);

    // flush while waiting in R; late DEADBEEF beat must be dropped
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0200;
    @(negedge clk);
    req_valid = 1'b0; i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0; flush = 1'b1;
    #1 chk("fr_rready", i_rready, 1);
    chk("fr_req_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("fr_no_resp1", resp_valid, 0);
    @(negedge clk);
    i_rvalid = 1'b1; i_rdata = 32'hDEAD_BEEF; i_rresp = 2'b00;
    #1 chk("fr_no_resp2", resp_valid, 0);
    @(negedge clk);
    i_rvalid = 1'b0;
    #1 chk("fr_no_resp3", resp_valid, 0);
    chk("fr_idle_ready", req_ready, 1);
    v = '{32'h8000_0100, 32'h0FF0_0F13, 2'b00, 0, 0, 3, 32'h0FF0_0F13, 1'b0, 1};
    run_fetch(v, 1'b1);

    // flush in AR with arready low: arvalid held, beat dropped
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0040;
    @(negedge clk);
    req_valid = 1'b0; i_arready = 1'b0; flush = 1'b1;
    #1 chk("fa_arvalid0", i_arvalid, 1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("fa_arvalid1", i_arvalid, 1);
    chk("fa_araddr", i_araddr, 32'h8000_0040);
    @(negedge clk);
    i_arready = 1'b1;
    #1 chk("fa_arvalid2", i_arvalid, 1);
    @(negedge clk);
    i_arready = 1'b0; i_rvalid = 1'b1; i_rdata = 32'h5555_AAAA;
    #1 chk("fa_rready", i_rready, 1);
    @(negedge clk);
    i_rvalid = 1'b0;
    #1 chk("fa_no_resp", resp_valid, 0);
    chk("fa_idle_ready", req_ready, 1);
    chk("fa_arvalid_low", i_arvalid, 0);

    // HOLD backpressure: five stalled cycles with a competing request
    v = '{32'h8000_0080, 32'h0000_0073, 2'b00, 0, 0, 3, 32'h0000_0073, 1'b0, 1};
    run_fetch(v, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h8000_0300; resp_ready = 1'b0;
      #1 chk("hold_valid", resp_valid, 1);
      chk("hold_inst", resp_inst, 32'h0000_0073);
      chk("hold_pc", resp_pc, 32'h8000_0080);
      chk("hold_err", resp_err, 0);
      chk("hold_req_ready", req_ready, 0);
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1 chk("hold_consumed", resp_valid, 0);
    chk("hold_no_ar", i_arvalid, 0);
    chk("hold_idle_ready", req_ready, 1);

    // flush in HOLD drops the response without resp_ready
    run_fetch(vecs[4], 1'b0);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("fh_req_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("fh_dropped", resp_valid, 0);
    chk("fh_ready", req_ready, 1);

    // reset while in R
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0020;
    @(negedge clk);
    req_valid = 1'b0; i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0; rst = 1'b1;
    #1 chk("rr_in_r", i_rready, 1);
    chk("rr_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_outputs("rst_in_r");

    random_run(3000);

    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_outputs("final_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
